instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Byte-stream program loader that fills the processor's byte-organised instruction memory at run time, replacing the static hex-file image. It accepts a framed stream of a 2-byte length header, N program bytes and a 1-byte XOR checksum over a valid/ready handshake. It writes each byte to the memory's write port at consecutive byte addresses. While loading, it holds the CPU in reset through `cpu_hold`.

## Interface
- `MEM_BYTES`, default 1024: instruction memory capacity in bytes; the largest legal N.
- `ADDR_W`, default 32: width of `mem_addr`, matching the instruction fetch address width.

- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, active-low and synchronous (already decided).
- `start`  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid && in_ready`.
- `mem_we`  out  1  byte write strobe to instruction memory.
- `mem_addr`  out  ADDR_W  byte address of the write.
- `mem_wdata`  out  8  byte to write.
- `busy`  out  1  a load is in progress.
- `done`  out  1  last load completed with a good checksum; level output.
- `err_len`  out  1  last load was rejected because N == 0 or N > MEM_BYTES; level output.
- `err_csum`  out  1  last load failed its checksum; level output.
- `cpu_hold`  out  1  keep the CPU in reset; deassert only on a successful load.

## Operation
- States: IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR.
- IDLE → HDR0 on `start`. DONE and ERR also go to HDR0 on `start`. Entering HDR0 clears `done`, `err_len`, `err_csum`, the byte counter and the checksum, and sets `cpu_hold` = 1.
- HDR0: the transferred byte is N[7:0].
- HDR1: the transferred byte is N[15:8].
  - If the assembled N is 0 or greater than MEM_BYTES, go to ERR with `err_len` = 1.
  - Otherwise go to DATA.
- DATA: the k-th transferred byte (k = 0..N-1) is written to address k. The checksum accumulates `csum ^= in_data`. After byte N-1, go to CSUM.
- CSUM: the transferred byte is compared with `csum`.
  - Equal: go to DONE, `done` = 1, `cpu_hold` = 0.
  - Not equal: go to ERR, `err_csum` = 1.
- `in_ready` = 1 exactly in HDR0, HDR1, DATA and CSUM. `busy` = 1 in those same states.
- Memory contents are never erased. After an ERR the image may be partial, so `cpu_hold` stays 1.
- `start` while busy is ignored; the load in progress continues unaffected.
- Bytes presented in IDLE, DONE or ERR are not accepted (`in_ready` = 0).
- The byte counter is 16 bits and cannot wrap, because N ≤ MEM_BYTES ≤ 65535 is checked in HDR1.
- `mem_addr` is the counter zero-extended to ADDR_W.

## Timing
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `err_len` 0, `err_csum` 0, `cpu_hold` 1.
- Reset asserted in any state returns the block to IDLE on the next edge. A write registered in that same cycle is suppressed. Bytes already written remain in memory.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. A DATA byte transferred in cycle t is written with `mem_we` = 1 in cycle t+1. `mem_we` is 1 for exactly one cycle per data byte.
- Throughput is one byte per cycle under continuous `in_valid`.
- `in_valid` gaps stall the FSM with no state change and no write.
- Minimum load time is N+3 accepted bytes. `done`/`err_*` assert in the cycle after the CSUM byte transfers.
- `err_len` asserts in the cycle after the HDR1 byte transfers.
- `start` and a transfer in the same cycle while in DONE/ERR: `start` wins and the byte is not accepted, because `in_ready` is 0 in that cycle.

## Structure
- Package `instr_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `HDR_BYTES` = 2;
  - the width constant `LEN_W` = 16.
- The block is flat with no sub-module. The FSM, 16-bit counter, 8-bit XOR accumulator and output registers fit in one module.

## Test plan
- **Good load:** `start`, then stream 04 00 13 00 00 00 13 → writes 13@0, 00@1, 00@2, 00@3, then `done` = 1, `cpu_hold` = 0, `busy` = 0, no errors.
- **Length reject:** stream 01 04 (N = 1025) → ERR after HDR1, `err_len` = 1, zero `mem_we` pulses, `cpu_hold` = 1. Stream 00 00 → same result.
- **Bad checksum:** 02 00 AA 55 00 (expected FF) → two writes, then `err_csum` = 1 and `cpu_hold` = 1. A following `start` with a good frame → `done` = 1.
- **Backpressure:** good 8-byte frame with `in_valid` toggling every other cycle → exactly 8 writes at addresses 0..7 in order, no duplicates, `done` = 1.
- **Reset mid-DATA:** `reset_n` = 0 after 3 of 8 data bytes → next cycle IDLE, all outputs at reset values, no further `mem_we`.
- **Start while busy:** `start` pulsed during DATA → ignored; load completes with the original N and the correct checksum.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the byte-stream instruction memory loader.
//   loader_state_t : FSM states of the loader
//   HDR_BYTES      : number of length-header bytes in front of the program
//   LEN_W          : width of the program length and of the byte counter
// ---------------------------------------------------------------------------
package instr_loader_pkg;

  localparam int HDR_BYTES = 2;
  localparam int LEN_W     = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
// Bundles the loader's byte stream handshake, the instruction memory write
// port and the load status flags.
//   start, in_data, in_valid          : host -> loader stream
//   in_ready                          : loader -> host stream back-pressure
//   mem_we, mem_addr, mem_wdata       : loader -> instruction memory
//   busy, done, err_len, err_csum     : load status levels
//   cpu_hold                          : keeps the CPU in reset
// Modports:
//   master : the host side that frames and sends the program
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface instr_mem_loader_if #(
  parameter int ADDR_W = 32
);
  import instr_loader_pkg::*;

  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              err_len;
  logic              err_csum;
  logic              cpu_hold;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  busy, done, err_len, err_csum, cpu_hold
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output busy, done, err_len, err_csum, cpu_hold
  );

endinterface

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Loads a program into the byte-organised instruction memory at run time.
// Frame: N[7:0], N[15:8], N program bytes, one XOR checksum byte.
// Program byte k is written to address k; the CPU is held in reset until a
// load finishes with a matching checksum.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : instr_mem_loader_if slave modport (stream, memory, status)
// Parameters:
//   MEM_BYTES : memory capacity, largest legal N (must be <= 65535)
//   ADDR_W    : width of mem_addr, must match the interface's ADDR_W
// ---------------------------------------------------------------------------
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_mem_loader_if.slave   bus
);

  loader_state_t     state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  byteCount_q;
  logic [7:0]        csum_q;
  logic              inReady_q;
  logic              busy_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [7:0]        memWdata_q;
  logic              done_q;
  logic              errLen_q;
  logic              errCsum_q;
  logic              cpuHold_q;

  logic              xfer_d;
  logic [LEN_W-1:0]  lenFull_d;
  logic              lenBad_d;
  logic              lastByte_d;

  // A byte moves only when the loader is ready. The length is assembled from
  // the low byte captured in HDR0 and the byte currently on the stream, so
  // the range check can be made in the same cycle the high byte arrives.
  // The 32-bit compare keeps the check exact for any legal MEM_BYTES.
  always_comb begin
    xfer_d     = bus.in_valid && inReady_q;
    lenFull_d  = {bus.in_data, len_q[7:0]};
    lenBad_d   = (lenFull_d == '0) || (32'(lenFull_d) > 32'(MEM_BYTES));
    lastByte_d = (byteCount_q == (len_q - LEN_W'(1)));
  end

  // Single FSM register block. All outputs are registered alongside the
  // state: in_ready/busy are updated whenever the state enters or leaves
  // the streaming states, and the memory write strobe defaults low so each
  // data byte produces exactly one write pulse. Reset overrides everything,
  // which also drops any write registered in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      byteCount_q <= '0;
      csum_q      <= '0;
      inReady_q   <= 1'b0;
      busy_q      <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      done_q      <= 1'b0;
      errLen_q    <= 1'b0;
      errCsum_q   <= 1'b0;
      cpuHold_q   <= 1'b1;
    end else begin
      memWe_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            state_q     <= HDR0;
            inReady_q   <= 1'b1;
            busy_q      <= 1'b1;
            byteCount_q <= '0;
            csum_q      <= '0;
            done_q      <= 1'b0;
            errLen_q    <= 1'b0;
            errCsum_q   <= 1'b0;
            cpuHold_q   <= 1'b1;
          end
        end
        HDR0: begin
          if (xfer_d) begin
            len_q[7:0] <= bus.in_data;
            state_q    <= HDR1;
          end
        end
        HDR1: begin
          if (xfer_d) begin
            len_q <= lenFull_d;
            if (lenBad_d) begin
              state_q   <= ERR;
              errLen_q  <= 1'b1;
              inReady_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer_d) begin
            memWe_q     <= 1'b1;
            memAddr_q   <= ADDR_W'(byteCount_q);
            memWdata_q  <= bus.in_data;
            csum_q      <= csum_q ^ bus.in_data;
            byteCount_q <= byteCount_q + LEN_W'(1);
            if (lastByte_d) begin
              state_q <= CSUM;
            end
          end
        end
        CSUM: begin
          if (xfer_d) begin
            inReady_q <= 1'b0;
            busy_q    <= 1'b0;
            if (bus.in_data == csum_q) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              cpuHold_q <= 1'b0;
            end else begin
              state_q   <= ERR;
              errCsum_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          inReady_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.busy      = busy_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.done      = done_q;
  assign bus.err_len   = errLen_q;
  assign bus.err_csum  = errCsum_q;
  assign bus.cpu_hold  = cpuHold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader. Expected memory writes are
// pushed to a queue when the bytes are driven and popped by a monitor that
// watches the write port; each scenario task checks status flags inline.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;
  import instr_loader_pkg::*;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int passCount = 0;
  int checkCount = 0;

  logic [ADDR_W+7:0] expQ[$];

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Status bundle: in_ready, mem_we, busy, done, err_len, err_csum, cpu_hold.
  function automatic logic [6:0] status();
    return {bus.in_ready, bus.mem_we, bus.busy, bus.done,
            bus.err_len, bus.err_csum, bus.cpu_hold};
  endfunction

  // Write monitor: every strobe seen on the falling edge must match the
  // oldest outstanding expected write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_write addr=%0h data=%02h required=none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [ADDR_W+7:0] exp;
        exp = expQ.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== exp) begin
          $display("[TB] FAIL write actual=%0h/%02h required=%0h/%02h",
                   bus.mem_addr, bus.mem_wdata, exp[ADDR_W+7:8], exp[7:0]);
        end else begin
          passCount++;
        end
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulseStart();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Drives one byte and waits (bounded) until it transfers.
  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      checkCount++;
      $display("[TB] FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendStream(input logic [7:0] s[$], input bit gaps);
    foreach (s[i]) begin
      sendByte(s[i]);
      if (gaps && i != s.size() - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic pushWrites(input logic [7:0] s[$]);
    foreach (s[i]) expQ.push_back({ADDR_W'(i), s[i]});
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkDrained(input string name);
    checkCount++;
    if (expQ.size() != 0) begin
      $display("[TB] FAIL %s_writes_pending actual=%0d required=0", name, expQ.size());
      expQ.delete();
    end else passCount++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idleCycles(3);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0000001)
      $display("[TB] FAIL reset_status actual=%b required=%b", status(), 7'b0000001);
    else passCount++;
    checkCount++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== 8'h00)
      $display("[TB] FAIL reset_bus actual=%0h/%02h required=0/00", bus.mem_addr, bus.mem_wdata);
    else passCount++;
    reset_n = 1'b1;
    idleCycles(2);
    @(negedge clk);
    checkCount++;
    if (bus.in_ready !== 1'b0)
      $display("[TB] FAIL idle_ready actual=%b required=0", bus.in_ready);
    else passCount++;
    @(posedge clk); #1;
  endtask

  task automatic test_good_load();
    logic [7:0] s[$];
    logic [7:0] d[$];
    d = '{8'h13, 8'h00, 8'h00, 8'h00};
    s = '{8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    pushWrites(d);
    pulseStart();
    sendStream(s, 1'b0);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0001000)
      $display("[TB] FAIL good_status actual=%b required=%b", status(), 7'b0001000);
    else passCount++;
    checkDrained("good");
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ignore();
    logic [7:0] s[$];
    logic [7:0] d[$];
    bus.in_data  = 8'h99;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkCount++;
      if (bus.in_ready !== 1'b0)
        $display("[TB] FAIL done_ready actual=%b required=0", bus.in_ready);
      else passCount++;
    end
    @(posedge clk); #1;
    bus.in_data = 8'h55;
    pulseStart();
    bus.in_valid = 1'b0;
    d = '{8'h7E};
    s = '{8'h01, 8'h00, 8'h7E, 8'h7E};
    pushWrites(d);
    sendStream(s, 1'b0);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0001000)
      $display("[TB] FAIL start_vs_byte_status actual=%b required=%b", status(), 7'b0001000);
    else passCount++;
    checkDrained("start_vs_byte");
    @(posedge clk); #1;
  endtask

  task automatic test_length_reject();
    logic [7:0] s[$];
    s = '{8'h01, 8'h04};
    pulseStart();
    sendStream(s, 1'b0);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0000101)
      $display("[TB] FAIL len_big_status actual=%b required=%b", status(), 7'b0000101);
    else passCount++;
    @(posedge clk); #1;
    s = '{8'h00, 8'h00};
    pulseStart();
    sendStream(s, 1'b0);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0000101)
      $display("[TB] FAIL len_zero_status actual=%b required=%b", status(), 7'b0000101);
    else passCount++;
    @(posedge clk); #1;
    idleCycles(3);
    checkDrained("len");
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s[$];
    logic [7:0] d[$];
    d = '{8'hAA, 8'h55};
    s = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
    pushWrites(d);
    pulseStart();
    sendStream(s, 1'b0);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0000011)
      $display("[TB] FAIL csum_bad_status actual=%b required=%b", status(), 7'b0000011);
    else passCount++;
    @(posedge clk); #1;
    s = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'hFF};
    pushWrites(d);
    pulseStart();
    sendStream(s, 1'b0);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0001000)
      $display("[TB] FAIL csum_retry_status actual=%b required=%b", status(), 7'b0001000);
    else passCount++;
    checkDrained("csum");
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] s[$];
    logic [7:0] d[$];
    logic [7:0] csum;
    csum = 8'h00;
    for (int i = 0; i < 8; i++) begin
      d.push_back(8'($urandom_range(0, 255)));
      csum = csum ^ d[i];
    end
    s = '{8'h08, 8'h00};
    foreach (d[i]) s.push_back(d[i]);
    s.push_back(csum);
    pushWrites(d);
    pulseStart();
    sendStream(s, 1'b1);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0001000)
      $display("[TB] FAIL backpressure_status actual=%b required=%b", status(), 7'b0001000);
    else passCount++;
    checkDrained("backpressure");
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    logic [7:0] d[$];
    logic [7:0] tail[$];
    d = '{8'h11, 8'h22, 8'h44, 8'h88};
    pushWrites(d);
    pulseStart();
    sendByte(8'h04);
    sendByte(8'h00);
    sendByte(8'h11);
    sendByte(8'h22);
    pulseStart();
    tail = '{8'h44, 8'h88, 8'hFF};
    sendStream(tail, 1'b0);
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0001000)
      $display("[TB] FAIL start_busy_status actual=%b required=%b", status(), 7'b0001000);
    else passCount++;
    checkDrained("start_busy");
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] d[$];
    d = '{8'hC1, 8'hC2, 8'hC3};
    pushWrites(d);
    pulseStart();
    sendByte(8'h08);
    sendByte(8'h00);
    sendByte(8'hC1);
    sendByte(8'hC2);
    sendByte(8'hC3);
    reset_n = 1'b0;
    bus.in_data  = 8'hC4;
    bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    checkCount++;
    if (status() !== 7'b0000001)
      $display("[TB] FAIL mid_reset_status actual=%b required=%b", status(), 7'b0000001);
    else passCount++;
    checkCount++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== 8'h00)
      $display("[TB] FAIL mid_reset_bus actual=%0h/%02h required=0/00", bus.mem_addr, bus.mem_wdata);
    else passCount++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idleCycles(4);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkCount++;
    if (status() !== 7'b0000001)
      $display("[TB] FAIL post_reset_status actual=%b required=%b", status(), 7'b0000001);
    else passCount++;
    checkDrained("mid_reset");
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    test_reset();
    test_good_load();
    test_idle_ignore();
    test_length_reject();
    test_bad_checksum();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_data();
    idleCycles(2);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
